div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Issue-side sequencer for the iterative integer divider in the register-file datapath.
- Accepts a decoded DIV/DIVU/REM/REMU request with operands, converts signed operands to magnitudes, and pulses div_inst to launch the datapath iteration.
- Waits for div_last, applies RISC-V sign and special-case rules, and presents the result for writeback.
- Sits between decode/execute and the register-file/divider datapath.

Parameters:
- TIMEOUT, 40: maximum WAIT cycles before the operation is aborted with err.
- XLEN, 32: operand and result width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request; high only in IDLE
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_rd  in  5  destination register
- req_a  in  32  dividend
- req_b  in  32  divisor
- div_inst  out  1  one-cycle launch pulse to the datapath
- div_a  out  32  dividend magnitude, held stable from START until DONE
- div_b  out  32  divisor magnitude, held stable from START until DONE
- div_last  in  1  datapath final-iteration flag
- dp_quot  in  32  unsigned quotient, valid in the div_last cycle
- dp_rem  in  32  unsigned remainder, valid in the div_last cycle
- wb_valid  out  1  result valid
- wb_ready  in  1  writeback consumer accepts the result
- wb_rd  out  5  destination register of the result
- wb_data  out  32  final result
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state=IDLE. All outputs are 0 except req_ready=1. Internal counter=0. Reset mid-operation aborts to IDLE with no writeback; a div_last arriving afterwards is ignored.
- States:
  - IDLE: req_ready=1. On accept (req_valid & req_ready at cycle T), latch op, rd, a and b.
    - Short path when b==0, or signed op with a==0x80000000 and b==0xFFFFFFFF: go to DONE at T+1. div_inst is never asserted.
    - Otherwise go to START.
  - START (T+1): div_inst=1 for exactly one cycle. Then go to WAIT with counter=0.
  - WAIT: counter increments each cycle.
    - div_last=1: capture dp_quot/dp_rem in that cycle L, then go to FIX.
    - Otherwise, counter==TIMEOUT-1: go to DONE with wb_data=0 and err=1 for one cycle.
  - FIX (L+1): compute the final result into a register. Then go to DONE.
  - DONE (L+2): wb_valid=1, with wb_rd and wb_data held stable until wb_ready. On wb_valid & wb_ready, go to IDLE. req_ready=0 until then.
- div_last is ignored outside WAIT.
- Magnitudes:
  - Signed ops: div_a=|a|, div_b=|b|, using 32-bit two's-complement negation (|0x80000000|=0x80000000).
  - Unsigned ops: raw operands.
- Sign fixup (signed ops only):
  - Quotient is negated iff a[31]^b[31].
  - Remainder is negated iff a[31].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases:
  - b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- Timing: latency from accept to wb_valid is 1 cycle on the short path and (L-T)+2 otherwise. Back-to-back requests are accepted in the cycle after a DONE handshake.

Optional Feature:
- Macro DIV_ONE_BYPASS_EN.
- Defined:
  - Unsigned op with b==1: short path; quotient=a, remainder=0.
  - Signed op with b==1 or b==0xFFFFFFFF: short path; quotient=a or -a (two's complement, with overflow still giving 0x80000000), remainder=0.
  - div_inst is not pulsed.
- Undefined: these cases use the normal datapath path (the overflow case stays on the short path regardless).

Test Plan:
- Bench stub: asserts div_last 31 cycles after div_inst with dp_quot=div_a/div_b and dp_rem=div_a%div_b.
- DIV a=0xFFFFFFF9 (-7), b=2 -> div_a=7, div_b=2; wb_data=0xFFFFFFFD. Same operands as REM -> 0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=0x10, accepted at T -> div_inst high only at T+1; wb_valid first high at T+34; wb_data=0x0FFFFFFF; busy high T+1..T+34.
- DIV a=5, b=0 -> wb_valid at T+1, wb_data=0xFFFFFFFF, div_inst never high. REM a=5, b=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- wb_ready low for 3 cycles in DONE -> wb_data/wb_rd stable and req_ready=0 throughout; accept on the 4th cycle, IDLE next.
- Reset asserted during WAIT -> IDLE next cycle, wb_valid=0. The stub's later div_last produces no writeback. A new DIVU 10/3 then yields 3.
- Stub never asserts div_last -> err pulse and DONE after TIMEOUT(40) WAIT cycles, wb_data=0. With DIV_ONE_BYPASS_EN: DIV 7 / 0xFFFFFFFF -> 0xFFFFFFF9 at T+1, no div_inst.

Source files
------------

// File: rtl/div_seq_if.sv
// div_seq_if: request, datapath and writeback signals of the divider sequencer.
// slave is the sequencer's view; master is the surrounding decode/datapath/writeback view.
interface div_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [4:0]      req_rd;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            div_inst;
    logic [XLEN-1:0] div_a;
    logic [XLEN-1:0] div_b;
    logic            div_last;
    logic [XLEN-1:0] dp_quot;
    logic [XLEN-1:0] dp_rem;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            busy;
    logic            err;

    modport slave (
        input  req_valid, req_op, req_rd, req_a, req_b,
        input  div_last, dp_quot, dp_rem, wb_ready,
        output req_ready, div_inst, div_a, div_b, wb_valid, wb_rd, wb_data, busy, err
    );

    modport master (
        output req_valid, req_op, req_rd, req_a, req_b,
        output div_last, dp_quot, dp_rem, wb_ready,
        input  req_ready, div_inst, div_a, div_b, wb_valid, wb_rd, wb_data, busy, err
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: issue-side sequencer for the iterative integer divider.
// Takes DIV/DIVU/REM/REMU requests, launches the datapath on operand magnitudes,
// applies RISC-V sign and special-case rules and holds the result for writeback.
// Optional feature macro: DIV_ONE_BYPASS_EN (divisor of 1, or -1 for signed ops,
// is resolved locally without launching the datapath).
module div_seq #(
    parameter int TIMEOUT = 40,
    parameter int XLEN    = 32
) (
    input  logic     clk,
    input  logic     reset,
    div_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] ONE  = XLEN'(1);

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] a_mag_q, a_mag_d;
    logic [XLEN-1:0] b_mag_q, b_mag_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;

    logic            req_signed;
    logic            bypass;
    logic            short_path;

    // Two's-complement magnitude; the most negative value maps onto itself.
    function automatic logic [XLEN-1:0] magnitude(input logic sgn, input logic [XLEN-1:0] x);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    // Result for requests that never reach the datapath.
    function automatic logic [XLEN-1:0] short_result(input logic [1:0] op,
                                                      input logic [XLEN-1:0] a,
                                                      input logic [XLEN-1:0] b);
        logic sgn;
        logic is_rem;
        sgn    = ~op[0];
        is_rem = op[1];
        if (b == '0)
            return is_rem ? a : ONES;
        if (sgn && a == SMIN && b == ONES)
            return is_rem ? '0 : SMIN;
        // Divide by +1 / -1 (only reachable with the bypass enabled).
        if (is_rem)
            return '0;
        return (sgn && b == ONES) ? -a : a;
    endfunction

    // Apply sign correction to the unsigned datapath result.
    function automatic logic [XLEN-1:0] fixup(input logic is_rem, input logic qneg,
                                              input logic rneg, input logic [XLEN-1:0] q,
                                              input logic [XLEN-1:0] r);
        if (is_rem)
            return rneg ? -r : r;
        return qneg ? -q : q;
    endfunction

    // Classify the incoming request: datapath launch or local short path.
    always_comb begin
        req_signed = ~bus.req_op[0];
`ifdef DIV_ONE_BYPASS_EN
        bypass     = (bus.req_b == ONE) || (req_signed && bus.req_b == ONES);
`else
        bypass     = 1'b0;
`endif
        short_path = (bus.req_b == '0)
                   || (req_signed && bus.req_a == SMIN && bus.req_b == ONES)
                   || bypass;
    end

    // Sequencer next-state and datapath capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        rd_d      = rd_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    is_rem_d = bus.req_op[1];
                    qneg_d   = req_signed && (bus.req_a[XLEN-1] ^ bus.req_b[XLEN-1]);
                    rneg_d   = req_signed && bus.req_a[XLEN-1];
                    rd_d     = bus.req_rd;
                    a_mag_d  = magnitude(req_signed, bus.req_a);
                    b_mag_d  = magnitude(req_signed, bus.req_b);
                    if (short_path) begin
                        wb_data_d = short_result(bus.req_op, bus.req_a, bus.req_b);
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.div_last) begin
                    quot_d  = bus.dp_quot;
                    rem_d   = bus.dp_rem;
                    state_d = S_FIX;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    wb_data_d = '0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                wb_data_d = fixup(is_rem_q, qneg_q, rneg_q, quot_q, rem_q);
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (bus.wb_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset clears everything so all outputs start at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            rd_q      <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            rd_q      <= rd_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.div_inst  = (state_q == S_START);
    assign bus.div_a     = a_mag_q;
    assign bus.div_b     = b_mag_q;
    assign bus.wb_valid  = (state_q == S_DONE);
    assign bus.wb_rd     = rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq with a fixed-latency datapath stub.
`timescale 1ns/1ps
module tb_div_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_seq_if #(.XLEN(32)) bus();

    div_seq #(.TIMEOUT(40), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Datapath stub: div_last 31 cycles after div_inst, with quotient/remainder of the magnitudes.
    logic        stub_en = 1'b1;
    int unsigned stub_cnt = 0;
    logic [31:0] stub_a = '0;
    logic [31:0] stub_b = '0;
    always @(posedge clk) begin
        if (stub_en && bus.div_inst) begin
            stub_cnt <= 1;
            stub_a   <= bus.div_a;
            stub_b   <= bus.div_b;
        end else if (stub_cnt == 31) begin
            stub_cnt <= 0;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt + 1;
        end
    end
    assign bus.div_last = (stub_cnt == 31);
    assign bus.dp_quot  = (stub_b != 0) ? stub_a / stub_b : 32'h0;
    assign bus.dp_rem   = (stub_b != 0) ? stub_a % stub_b : 32'h0;

    // Writeback monitor: pops the scoreboard on every handshake.
    always begin
        @(negedge clk);
        #2;
        if (bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wb_with_empty_queue", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_data"}, bus.wb_data, e.data);
                check({e.tag, "_rd"}, 32'(bus.wb_rd), 32'(e.rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic issue(input string tag, input logic [1:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rd    = rd;
        bus.req_a     = a;
        bus.req_b     = b;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, "_accept_timeout"}, 32'(n), 32'd0);
        if (push) exp_q.push_back('{tag, rd, exp});
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Count cycles from acceptance until wb_valid, observing div_inst and busy on the way.
    task automatic wait_valid(input string tag, output int lat, output int n_inst,
                              output int first_inst, output bit busy_all);
        lat = 1; n_inst = 0; first_inst = -1; busy_all = 1'b1;
        while (1) begin
            if (bus.div_inst === 1'b1) begin
                n_inst++;
                if (first_inst < 0) first_inst = lat;
            end
            if (bus.busy !== 1'b1) busy_all = 1'b0;
            if (bus.wb_valid === 1'b1 || lat >= 200) break;
            @(negedge clk);
            lat++;
        end
        if (bus.wb_valid !== 1'b1) check({tag, "_wb_valid_timeout"}, 32'(bus.wb_valid), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int exp_ninst, input bit exp_err);
        int lat, n_inst, first_inst;
        bit busy_all;
        logic [31:0] ma, mb;
        issue(tag, op, rd, a, b, exp, 1'b1);
        if (exp_ninst != 0) begin
            ma = (!op[0] && a[31]) ? (32'h0 - a) : a;
            mb = (!op[0] && b[31]) ? (32'h0 - b) : b;
            check({tag, "_div_a"}, bus.div_a, ma);
            check({tag, "_div_b"}, bus.div_b, mb);
        end
        wait_valid(tag, lat, n_inst, first_inst, busy_all);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_div_inst_count"}, 32'(n_inst), 32'(exp_ninst));
        if (exp_ninst != 0) check({tag, "_div_inst_cycle"}, 32'(first_inst), 32'd1);
        check({tag, "_busy"}, 32'(busy_all), 32'd1);
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        int  lat, n_inst, first_inst;
        bit  busy_all;
        bit  saw;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_rd    = 5'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.wb_ready  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_wb_valid",  32'(bus.wb_valid),  32'd0);
        check("rst_div_inst",  32'(bus.div_inst),  32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        check("rst_wb_data",   bus.wb_data,        32'd0);
        check("rst_wb_rd",     32'(bus.wb_rd),     32'd0);
        check("rst_div_a",     bus.div_a,          32'd0);

        // Signed/unsigned datapath operations.
        run_op("div_m7_2",   2'b00, 5'd1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, 1, 1'b0);
        run_op("rem_m7_2",   2'b10, 5'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 1, 1'b0);
        run_op("divu_big",   2'b01, 5'd3, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 34, 1, 1'b0);
        run_op("div_m20_m6", 2'b00, 5'd4, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'd3,        34, 1, 1'b0);
        run_op("rem_m20_m6", 2'b10, 5'd5, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 34, 1, 1'b0);
        run_op("div_20_m6",  2'b00, 5'd6, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 34, 1, 1'b0);
        run_op("remu_big",   2'b11, 5'd7, 32'hFFFF_FFFF, 32'd7,        32'd3,         34, 1, 1'b0);

        // Short-path special cases.
        run_op("div_5_0",    2'b00, 5'd8,  32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0, 1'b0);
        run_op("rem_5_0",    2'b10, 5'd9,  32'd5,        32'd0,        32'd5,         1, 0, 1'b0);
        run_op("divu_5_0",   2'b01, 5'd10, 32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0, 1'b0);
        run_op("remu_5_0",   2'b11, 5'd11, 32'd5,        32'd0,        32'd5,         1, 0, 1'b0);
        run_op("div_ovf",    2'b00, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
        run_op("rem_ovf",    2'b10, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, 0, 1'b0);

        // Writeback back-pressure for three cycles.
        bus.wb_ready = 1'b0;
        issue("stall", 2'b01, 5'd9, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_valid("stall", lat, n_inst, first_inst, busy_all);
        check("stall_latency", 32'(lat), 32'd34);
        for (int i = 0; i < 3; i++) begin
            check("stall_wb_valid",  32'(bus.wb_valid),  32'd1);
            check("stall_wb_data",   bus.wb_data,        32'd14);
            check("stall_wb_rd",     32'(bus.wb_rd),     32'd9);
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        check("stall_idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("stall_idle_wb_valid",  32'(bus.wb_valid),  32'd0);

        // Reset during WAIT aborts; the stale div_last must not produce a writeback.
        issue("abort", 2'b01, 5'd4, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        check("abort_in_wait_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_wb_valid",  32'(bus.wb_valid),  32'd0);
        check("abort_wb_data",   bus.wb_data,        32'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
        end
        check("abort_stale_last_ignored", 32'(saw), 32'd0);
        run_op("divu_10_3", 2'b01, 5'd14, 32'd10, 32'd3, 32'd3, 34, 1, 1'b0);

        // Datapath never finishes: timeout after 40 WAIT cycles.
        stub_en = 1'b0;
        run_op("timeout", 2'b00, 5'd15, 32'd9, 32'd2, 32'd0, 42, 1, 1'b1);
        check("timeout_err_pulse_end", 32'(bus.err), 32'd0);
        stub_en = 1'b1;

`ifdef DIV_ONE_BYPASS_EN
        run_op("div_7_m1",  2'b00, 5'd16, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 0, 1'b0);
        run_op("divu_by_1", 2'b01, 5'd17, 32'hDEAD_BEEF, 32'd1,        32'hDEAD_BEEF, 1, 0, 1'b0);
        run_op("rem_by_1",  2'b10, 5'd18, 32'hFFFF_FFF9, 32'd1,        32'd0,         1, 0, 1'b0);
`else
        run_op("div_7_m1",  2'b00, 5'd16, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 34, 1, 1'b0);
        run_op("divu_by_1", 2'b01, 5'd17, 32'hDEAD_BEEF, 32'd1,        32'hDEAD_BEEF, 34, 1, 1'b0);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
